// File: rtl/alu4b_seq_if.sv
// Connection between the operator sequencer and the alu4b datapath.
// The sequencer drives operands and operation; the ALU returns carries and the segment code.
interface alu4b_seq_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       s0;
  logic       s1;
  logic       cout_som;
  logic       cout_sub;
  logic [6:0] seg_out;

  modport master (
    output a, b, s0, s1,
    input  cout_som, cout_sub, seg_out
  );

  modport slave (
    input  a, b, s0, s1,
    output cout_som, cout_sub, seg_out
  );
endinterface

// File: rtl/alu4b_seq.sv
// Push-button sequencer for alu4b: enters A, B and the operation from the switches,
// waits a settle window, then latches the ALU response for display.
module alu4b_seq #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        btn,
  alu4b_seq_if.master alu,
  output logic [6:0]  res_seg,
  output logic        res_cout_som,
  output logic        res_cout_sub,
  output logic        valid,
  output logic        done,
  output logic [2:0]  stage
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       btn_q;
  logic       adv;

  assign adv   = btn & ~btn_q;
  assign stage = state;

  // btn_q resets high so a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD_A;
      cnt          <= 4'd0;
      btn_q        <= 1'b1;
      alu.a        <= 4'd0;
      alu.b        <= 4'd0;
      alu.s0       <= 1'b0;
      alu.s1       <= 1'b0;
      res_seg      <= 7'd0;
      res_cout_som <= 1'b0;
      res_cout_sub <= 1'b0;
      valid        <= 1'b0;
      done         <= 1'b0;
    end else begin
      btn_q <= btn;
      done  <= 1'b0;
      case (state)
        LOAD_A: if (adv) begin
          alu.a <= sw;
          state <= LOAD_B;
        end
        LOAD_B: if (adv) begin
          alu.b <= sw;
          state <= LOAD_OP;
        end
        LOAD_OP: if (adv) begin
          alu.s0 <= sw[0];
          alu.s1 <= sw[1];
          cnt    <= SETTLE_INIT;
          state  <= EXEC;
        end
        EXEC: begin
          // Presses are deliberately ignored while the ALU settles.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_seg      <= alu.seg_out;
            res_cout_som <= alu.cout_som;
            res_cout_sub <= alu.cout_sub;
            valid        <= 1'b1;
            done         <= 1'b1;
            state        <= SHOW;
          end
        end
        SHOW: if (adv) begin
          valid <= 1'b0;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4b_seq.sv
// Directed bench for alu4b_seq with a small alu4b behavioural responder.
module tb_alu4b_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic [6:0] res_seg;
  logic       res_cout_som;
  logic       res_cout_sub;
  logic       valid;
  logic       done;
  logic [2:0] stage;

  int n_vec = 0;
  int n_err = 0;

  alu4b_seq_if alu_if ();

  alu4b_seq #(.SETTLE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn          (btn),
    .alu          (alu_if),
    .res_seg      (res_seg),
    .res_cout_som (res_cout_som),
    .res_cout_sub (res_cout_sub),
    .valid        (valid),
    .done         (done),
    .stage        (stage)
  );

  always #5 clk = ~clk;

  // alu4b model: active-high gfedcba hex segments; carries computed for every op.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  logic [4:0] sum5, dif5;
  logic [3:0] alu_r;
  always_comb begin
    sum5 = {1'b0, alu_if.a} + {1'b0, alu_if.b};
    dif5 = {1'b0, alu_if.a} + {1'b0, ~alu_if.b} + 5'd1;
    alu_r = 4'd0;
    case ({alu_if.s1, alu_if.s0})
      2'b00: alu_r = sum5[3:0];
      2'b01: alu_r = dif5[3:0];
      2'b10: alu_r = alu_if.a & alu_if.b;
      default: alu_r = alu_if.a | alu_if.b;
    endcase
    alu_if.cout_som = sum5[4];
    alu_if.cout_sub = dif5[4];
    alu_if.seg_out  = seg7(alu_r);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    sw = v; btn = 1'b1; tick();
    btn = 1'b0; sw = $urandom_range(0, 15); tick();
  endtask

  // Enters A, B and op, then counts clocks after the op-latch edge until done.
  task automatic enter_and_run(input logic [3:0] av, input logic [3:0] bv, input logic [1:0] op,
                               input bit press_in_exec, output int lat, output int n_done);
    press(av);
    press(bv);
    sw = {2'b00, op}; btn = 1'b1; tick();
    btn = 1'b0;
    lat = -1; n_done = 0;
    for (int i = 1; i <= 12; i++) begin
      if (press_in_exec && i == 2) btn = 1'b1;
      if (press_in_exec && i == 3) btn = 1'b0;
      sw = $urandom_range(0, 15);
      tick();
      if (done) begin
        n_done++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b1; sw = 4'hF;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (stage !== 3'd0) begin n_err++; $display("FAIL reset_stage got %0d want 0", stage); end
    n_vec++; if (alu_if.a !== 4'd0 || alu_if.b !== 4'd0) begin n_err++; $display("FAIL reset_ab got a=%h b=%h want 0 0", alu_if.a, alu_if.b); end
    n_vec++; if (valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags got valid=%b done=%b want 0 0", valid, done); end
    n_vec++; if (res_seg !== 7'd0 || {alu_if.s1, alu_if.s0} !== 2'b00) begin n_err++; $display("FAIL reset_res got seg=%h op=%b want 0 0", res_seg, {alu_if.s1, alu_if.s0}); end
    btn = 1'b0; tick();
  endtask

  task automatic test_add();
    int lat, nd;
    enter_and_run(4'b1010, 4'b0110, 2'b00, 1'b0, lat, nd);
    n_vec++; if (alu_if.a !== 4'b1010 || alu_if.b !== 4'b0110) begin n_err++; $display("FAIL add_operands got a=%b b=%b want 1010 0110", alu_if.a, alu_if.b); end
    n_vec++; if ({alu_if.s1, alu_if.s0} !== 2'b00) begin n_err++; $display("FAIL add_op got %b want 00", {alu_if.s1, alu_if.s0}); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL add_latency got %0d want 4", lat); end
    n_vec++; if (nd !== 1) begin n_err++; $display("FAIL add_done_count got %0d want 1", nd); end
    n_vec++; if (valid !== 1'b1 || stage !== 3'd4) begin n_err++; $display("FAIL add_show got valid=%b stage=%0d want 1 4", valid, stage); end
    n_vec++; if (res_seg !== 7'h3F || res_cout_som !== 1'b1) begin n_err++; $display("FAIL add_result got seg=%h cs=%b want 3f 1", res_seg, res_cout_som); end
  endtask

  task automatic test_sub();
    int lat, nd;
    sw = 4'h0; btn = 1'b1; tick(); btn = 1'b0; tick();
    n_vec++; if (stage !== 3'd0 || valid !== 1'b0 || res_seg !== 7'h3F) begin n_err++; $display("FAIL sub_hold_prev got stage=%0d valid=%b seg=%h want 0 0 3f", stage, valid, res_seg); end
    enter_and_run(4'b1010, 4'b0110, 2'b01, 1'b0, lat, nd);
    n_vec++; if ({alu_if.s1, alu_if.s0} !== 2'b01) begin n_err++; $display("FAIL sub_op got %b want 01", {alu_if.s1, alu_if.s0}); end
    n_vec++; if (res_seg !== 7'h66 || res_cout_sub !== 1'b1) begin n_err++; $display("FAIL sub_result got seg=%h cb=%b want 66 1", res_seg, res_cout_sub); end
    n_vec++; if (nd !== 1 || lat !== 4) begin n_err++; $display("FAIL sub_done got count=%0d lat=%0d want 1 4", nd, lat); end
  endtask

  task automatic test_and_or();
    int lat, nd;
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL andor_valid_before got %b want 1", valid); end
    sw = 4'h0; btn = 1'b1; tick();
    n_vec++; if (stage !== 3'd0 || valid !== 1'b0) begin n_err++; $display("FAIL andor_leave_show got stage=%0d valid=%b want 0 0", stage, valid); end
    btn = 1'b0; tick();
    enter_and_run(4'b1010, 4'b0110, 2'b10, 1'b0, lat, nd);
    n_vec++; if (res_seg !== 7'h5B || res_cout_som !== 1'b1) begin n_err++; $display("FAIL and_result got seg=%h cs=%b want 5b 1", res_seg, res_cout_som); end
    press(4'h0);
    enter_and_run(4'b1010, 4'b0110, 2'b11, 1'b0, lat, nd);
    n_vec++; if (res_seg !== 7'h79 || {alu_if.s1, alu_if.s0} !== 2'b11) begin n_err++; $display("FAIL or_result got seg=%h op=%b want 79 11", res_seg, {alu_if.s1, alu_if.s0}); end
  endtask

  task automatic test_exec_press();
    int lat, nd;
    press(4'h0);
    enter_and_run(4'b0011, 4'b0101, 2'b00, 1'b1, lat, nd);
    n_vec++; if (nd !== 1 || lat !== 4) begin n_err++; $display("FAIL exec_press_done got count=%0d lat=%0d want 1 4", nd, lat); end
    n_vec++; if (stage !== 3'd4) begin n_err++; $display("FAIL exec_press_stage got %0d want 4", stage); end
    n_vec++; if (res_seg !== 7'h7F || res_cout_som !== 1'b0 || res_cout_sub !== 1'b0) begin n_err++; $display("FAIL exec_press_result got seg=%h cs=%b cb=%b want 7f 0 0", res_seg, res_cout_som, res_cout_sub); end
  endtask

  task automatic test_back_to_back();
    int lat, nd;
    press(4'h0);
    enter_and_run(4'b0011, 4'b0101, 2'b01, 1'b0, lat, nd);
    n_vec++; if (res_seg !== 7'h79 || res_cout_sub !== 1'b0 || nd !== 1) begin n_err++; $display("FAIL b2b_sub got seg=%h cb=%b done=%0d want 79 0 1", res_seg, res_cout_sub, nd); end
  endtask

  task automatic test_mid_reset();
    bit seen_done;
    press(4'h0);
    press(4'b1100);
    press(4'b0011);
    sw = 4'b0001; btn = 1'b1; tick();
    btn = 1'b0; tick();
    n_vec++; if (stage !== 3'd3) begin n_err++; $display("FAIL mreset_in_exec got stage=%0d want 3", stage); end
    rst = 1'b1; tick();
    rst = 1'b0;
    n_vec++; if (stage !== 3'd0 || valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mreset_state got stage=%0d valid=%b done=%b want 0 0 0", stage, valid, done); end
    n_vec++; if (alu_if.a !== 4'd0 || alu_if.b !== 4'd0 || {alu_if.s1, alu_if.s0} !== 2'b00 || res_seg !== 7'd0) begin n_err++; $display("FAIL mreset_regs got a=%h b=%h op=%b seg=%h want 0 0 0 0", alu_if.a, alu_if.b, {alu_if.s1, alu_if.s0}, res_seg); end
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    n_vec++; if (seen_done !== 1'b0 || stage !== 3'd0) begin n_err++; $display("FAIL mreset_no_capture got done_seen=%b stage=%0d want 0 0", seen_done, stage); end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = 4'h0;
    test_reset();
    test_add();
    test_sub();
    test_and_or();
    test_exec_press();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
